// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: waits a random number of milliseconds,
// lights the cue LED, then measures how long the player takes to press the
// button. Reports a valid time, a false start or a timeout.
module reaction_sequencer #(
   parameter int unsigned CLKS_PER_MS  = 100000,
   parameter int unsigned MAX_REACT_MS = 9999
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        Button,
   input  logic [12:0] RandomValue,
   output logic        Led,
   output logic [13:0] ReactTime,
   output logic        Done,
   output logic        FalseStart,
   output logic        Timeout,
   output logic        Busy
);

   localparam int unsigned DIV_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_MS - 1);
   localparam logic [13:0]      REACT_MAX  = 14'(MAX_REACT_MS);
   localparam logic [13:0]      REACT_LAST = 14'(MAX_REACT_MS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REACT,
      S_RESULT
   } state_t;

   state_t           state_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [12:0]      delay_cnt_q;
   logic [13:0]      react_cnt_q;
   logic             button_prev_q;

   logic tick;
   logic press;

   // Millisecond tick and button rising-edge detect.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      tick  = (div_cnt_q == DIV_LAST);
      press = Button & ~button_prev_q;
   end

   // Round sequencing with registered outputs; Done defaults low so it pulses for one cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= S_IDLE;
         div_cnt_q     <= '0;
         delay_cnt_q   <= '0;
         react_cnt_q   <= '0;
         button_prev_q <= 1'b0;
         Led           <= 1'b0;
         ReactTime     <= '0;
         Done          <= 1'b0;
         FalseStart    <= 1'b0;
         Timeout       <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment in the
         // same cycle overrides the default, and every read sees the old value.
         button_prev_q <= Button;
         Done          <= 1'b0;

         case (state_q)
            S_IDLE, S_RESULT: begin
               // Outputs of a finished round hold here until the next Start.
               if (Start) begin
                  state_q     <= S_WAIT;
                  delay_cnt_q <= (RandomValue == 13'd0) ? 13'd1 : RandomValue;
                  div_cnt_q   <= '0;
                  ReactTime   <= '0;
                  FalseStart  <= 1'b0;
                  Timeout     <= 1'b0;
                  Busy        <= 1'b1;
               end
            end

            S_WAIT: begin
               if (press) begin
                  // A press before the cue wins even over the final delay tick.
                  state_q    <= S_RESULT;
                  FalseStart <= 1'b1;
                  ReactTime  <= '0;
                  Done       <= 1'b1;
                  Busy       <= 1'b0;
               end else if (tick) begin
                  div_cnt_q   <= '0;
                  delay_cnt_q <= delay_cnt_q - 13'd1;
                  if (delay_cnt_q == 13'd1) begin
                     state_q     <= S_REACT;
                     Led         <= 1'b1;
                     react_cnt_q <= '0;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end

            S_REACT: begin
               if (press) begin
                  // Report the count before any same-cycle tick increment.
                  state_q   <= S_RESULT;
                  ReactTime <= react_cnt_q;
                  Led       <= 1'b0;
                  Done      <= 1'b1;
                  Busy      <= 1'b0;
               end else if (tick) begin
                  div_cnt_q <= '0;
                  if (react_cnt_q == REACT_LAST) begin
                     state_q     <= S_RESULT;
                     react_cnt_q <= REACT_MAX;
                     ReactTime   <= REACT_MAX;
                     Timeout     <= 1'b1;
                     Led         <= 1'b0;
                     Done        <= 1'b1;
                     Busy        <= 1'b0;
                  end else begin
                     react_cnt_q <= react_cnt_q + 14'd1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Directed bench for reaction_sequencer with a 4-cycle millisecond and a
// 7 ms reaction limit, so every expected cycle count is easy to hand-derive.
module tb_reaction_sequencer;

   localparam int unsigned CPM = 4;
   localparam int unsigned MAX = 7;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic        Button;
   logic [12:0] RandomValue;
   logic        Led;
   logic [13:0] ReactTime;
   logic        Done;
   logic        FalseStart;
   logic        Timeout;
   logic        Busy;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int led_cnt  = 0;
   int done_snap;
   int led_snap;
   int n;

   reaction_sequencer #(
      .CLKS_PER_MS (CPM),
      .MAX_REACT_MS(MAX)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Start      (Start),
      .Button     (Button),
      .RandomValue(RandomValue),
      .Led        (Led),
      .ReactTime  (ReactTime),
      .Done       (Done),
      .FalseStart (FalseStart),
      .Timeout    (Timeout),
      .Busy       (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count Done pulses and Led-high cycles away from the active edge.
   always @(negedge Clk) begin
      if (Done) done_cnt++;
      if (Led)  led_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge Clk);
      #1;
   endtask

   // Pulse Start for one edge; RandomValue is scrambled afterwards to show it is not re-sampled.
   task automatic start_round(input logic [12:0] rv);
      done_snap   = done_cnt;
      led_snap    = led_cnt;
      RandomValue = rv;
      Start       = 1'b1;
      step(1);
      Start       = 1'b0;
      RandomValue = 13'h1abc;
   endtask

   // Edges until Led is seen high, bounded.
   task automatic wait_led(output int cycles);
      cycles = 0;
      while (!Led && cycles < 200) begin
         step(1);
         cycles++;
      end
   endtask

   // Edges until Done is seen high, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!Done && cycles < 200) begin
         step(1);
         cycles++;
      end
   endtask

   // Button rises so the k-th edge from now samples the press.
   task automatic press_at(input int k);
      if (k > 1) step(k - 1);
      Button = 1'b1;
      step(1);
      Button = 1'b0;
   endtask

   // Outcome check in the first RESULT cycle, then verify Done lasted one cycle.
   task automatic check_result(input string tag, input int rt, input bit fs, input bit to);
      check({tag, " done"},       32'(Done), 32'd1);
      check({tag, " react_time"}, 32'(ReactTime), 32'(rt));
      check({tag, " false_start"}, 32'(FalseStart), 32'(fs));
      check({tag, " timeout"},    32'(Timeout), 32'(to));
      check({tag, " led"},        32'(Led), 32'd0);
      check({tag, " busy"},       32'(Busy), 32'd0);
      step(1);
      check({tag, " done_low"},   32'(Done), 32'd0);
      check({tag, " done_count"}, 32'(done_cnt - done_snap), 32'd1);
   endtask

   initial begin
      Rst = 1'b1; Start = 1'b0; Button = 1'b0; RandomValue = '0;
      step(3);
      Rst = 1'b0;
      check("rst led",         32'(Led), 32'd0);
      check("rst react_time",  32'(ReactTime), 32'd0);
      check("rst done",        32'(Done), 32'd0);
      check("rst false_start", 32'(FalseStart), 32'd0);
      check("rst timeout",     32'(Timeout), 32'd0);
      check("rst busy",        32'(Busy), 32'd0);
      step(2);

      // Valid round: delay 3 ms -> Led after 12 cycles; press 10 cycles later -> 2 ms.
      start_round(13'd3);
      check("valid busy", 32'(Busy), 32'd1);
      wait_led(n);
      check("valid led_delay", 32'(n), 32'd12);
      press_at(10);
      check_result("valid", 2, 1'b0, 1'b0);
      step(3);

      // False start 6 cycles into a 5 ms wait.
      start_round(13'd5);
      press_at(6);
      check_result("false", 0, 1'b1, 1'b0);
      step(30);
      check("false led_never", 32'(led_cnt - led_snap), 32'd0);
      check("false hold flag", 32'(FalseStart), 32'd1);

      // Timeout: Led high 28 cycles then ReactTime=7.
      start_round(13'd1);
      wait_led(n);
      check("timeout led_delay", 32'(n), 32'd4);
      wait_done(n);
      check("timeout react_cycles", 32'(n), 32'd28);
      check("timeout led_cycles", 32'(led_cnt - led_snap), 32'd28);
      check_result("timeout", 7, 1'b0, 1'b1);

      // Button held through Start and the cue, then a fresh press 9 cycles after Led.
      Button = 1'b1;
      step(2);
      start_round(13'd2);
      Button = 1'b1;
      wait_led(n);
      check("held led_delay", 32'(n), 32'd8);
      check("held no_false", 32'(FalseStart), 32'd0);
      Button = 1'b0;
      press_at(9);
      check_result("held", 2, 1'b0, 1'b0);

      // Press on the final WAIT tick: false start wins.
      start_round(13'd3);
      press_at(12);
      check_result("coll_wait", 0, 1'b1, 1'b0);

      // Press on a REACT tick with ReactCnt=4.
      start_round(13'd1);
      wait_led(n);
      press_at(20);
      check_result("coll_react", 4, 1'b0, 1'b0);

      // Press on the timeout tick is a valid press with ReactCnt=6.
      start_round(13'd1);
      wait_led(n);
      press_at(28);
      check_result("coll_timeout", 6, 1'b0, 1'b0);

      // RandomValue=0 behaves as 1 ms.
      start_round(13'd0);
      wait_led(n);
      check("zero led_delay", 32'(n), 32'd4);
      press_at(5);
      check_result("zero", 1, 1'b0, 1'b0);

      // Start during WAIT ignored: still 12 cycles total for a 3 ms delay.
      start_round(13'd3);
      step(4);
      Start = 1'b1; RandomValue = 13'd1;
      step(1);
      Start = 1'b0;
      wait_led(n);
      check("restart_ignored led_delay", 32'(n), 32'd7);
      press_at(5);
      check_result("restart_ignored", 1, 1'b0, 1'b0);

      // Reset during REACT aborts without Done; the next round runs normally.
      start_round(13'd1);
      wait_led(n);
      step(2);
      Rst = 1'b1;
      step(1);
      Rst = 1'b0;
      check("abort led",  32'(Led), 32'd0);
      check("abort busy", 32'(Busy), 32'd0);
      step(20);
      check("abort no_done", 32'(done_cnt - done_snap), 32'd0);
      check("abort led_stays_low", 32'(Led), 32'd0);
      start_round(13'd2);
      wait_led(n);
      check("after_abort led_delay", 32'(n), 32'd8);
      press_at(6);
      check_result("after_abort", 1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/reaction_sequencer.md
Name: reaction_sequencer

Overview:
Controls one round of the reaction-time game. On Start it latches the 13-bit random delay value (milliseconds) from the random generator and waits that many milliseconds. It then lights the cue LED and measures, in milliseconds, the time until the player presses the button. It reports a false start, a timeout or a valid reaction time to the display/score logic.

Parameters:
CLKS_PER_MS, 100000, Clk cycles per millisecond tick (100 MHz board clock); bench overrides with a small value.
MAX_REACT_MS, 9999, reaction count at which the round times out (fits a 4-digit display).

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
Start  input  1  begin-round request, level-sampled, one-cycle pulse expected
Button  input  1  player button, already synchronised and debounced, active-high level
RandomValue  input  13  delay in ms from the random generator, sampled only when a round starts
Led  output  1  cue light, high while waiting for the player
ReactTime  output  14  measured reaction in ms, held until the next round starts
Done  output  1  one-cycle pulse when a round ends (any outcome)
FalseStart  output  1  sticky flag: button pressed before the cue
Timeout  output  1  sticky flag: no press within MAX_REACT_MS
Busy  output  1  high in WAIT and REACT

Behaviour:
- Reset (Clk edge with Rst=1):
  - state=IDLE.
  - Led, ReactTime, Done, FalseStart, Timeout, Busy = 0.
  - Internal counters = 0; ButtonPrev = 0.
  - Reset mid-round aborts immediately, with no Done pulse.
- Button edge detect: ButtonPrev is registered every cycle. A press is Button=1 with ButtonPrev=0. Only rising edges count, so a button held through a state change never triggers an event.
- ms tick:
  - DivCnt increments each cycle in WAIT/REACT and is cleared to 0 on entry to WAIT and to REACT.
  - Tick is active in the cycle where DivCnt==CLKS_PER_MS-1; DivCnt wraps to 0 on that cycle.
- States:
  - IDLE:
    - Start=1 -> WAIT.
    - DelayCnt <= RandomValue; if RandomValue==0, load 1.
    - Clear ReactTime, FalseStart, Timeout. Busy<=1.
  - WAIT:
    - Each tick decrements DelayCnt.
    - Tick with DelayCnt==1 -> REACT, Led<=1, ReactCnt<=0.
    - Led rises exactly D*CLKS_PER_MS cycles after the Start-sampling edge, where D is the loaded delay.
    - A press in WAIT -> RESULT, FalseStart<=1, ReactTime<=0, Done pulse, Busy<=0.
    - If a press and the final tick occur in the same cycle, the false start wins.
  - REACT:
    - Each tick increments ReactCnt.
    - Press -> RESULT, ReactTime<=ReactCnt (value before any same-cycle increment), Led<=0, Done pulse, Busy<=0.
    - Tick with ReactCnt==MAX_REACT_MS-1 and no press -> RESULT, ReactTime<=MAX_REACT_MS, Timeout<=1, Led<=0, Done pulse.
    - A press in the same cycle as the timeout tick is a valid press and takes priority over the timeout.
  - RESULT:
    - Outputs hold.
    - Start=1 behaves exactly as Start in IDLE: new round, flags cleared.
    - Button is ignored.
- Start in WAIT or REACT is ignored.
- RandomValue changes are ignored except on the Start-sampling cycle.
- Done is high for exactly one cycle per completed round. It is registered and asserted in the first cycle of RESULT.
- ReactTime width: 14 bits. ReactCnt never exceeds MAX_REACT_MS.

Test Plan:
- Valid round: CLKS_PER_MS=4, RandomValue=3, Start pulse; press 10 cycles after Led rises.
  - Led rises 12 cycles after the Start edge.
  - ReactTime=2, Done pulses once, FalseStart=0, Timeout=0, Busy falls with Done.
- False start: RandomValue=5, press 6 cycles into WAIT.
  - FalseStart=1, ReactTime=0, Led never rises, Done pulses once.
- Timeout: MAX_REACT_MS=7, no press.
  - Led stays high for 28 cycles, then Timeout=1, ReactTime=7, Led=0, Done pulses.
- Held button: Button=1 held from before Start through Led rising, then released and pressed 9 cycles after Led rises.
  - No false start; ReactTime=2.
- Edge collisions: press on the final WAIT tick cycle -> FalseStart=1. Press on a REACT tick cycle with ReactCnt=4 -> ReactTime=4.
- Misc:
  - RandomValue=0 -> Led rises 4 cycles after Start.
  - Start during WAIT ignored.
  - Rst during REACT -> Led=0, Busy=0, no Done; a following Start runs a normal round.
